// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register addressing and default datapath width.
package cpu_pkg;

    localparam int RAW      = 5;
    localparam int XLEN     = 32;
    localparam int ZERO_REG = 0;

    typedef logic [RAW-1:0] reg_addr_t;

endpackage

// File: rtl/load_scoreboard.sv
// Per-register count of outstanding loads; produces the decode load-use stall.
module load_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int CW   = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t rna,
    input  reg_addr_t rnb,
    input  logic      we,
    input  reg_addr_t wn,
    input  logic      wb_load,
    input  logic      iss_load,
    input  reg_addr_t iss_rd,
    output logic      stall
);

    localparam logic [CW-1:0] PMAX = '1;

    logic [CW-1:0] pend_q [NREG];
    logic [CW-1:0] pend_d [NREG];
    logic          retire;
    logic          busy_a;
    logic          busy_b;
    logic          full;

    // Effective count is non-zero unless the only pending load retires right now;
    // an untracked retire on an empty counter never makes it look busy.
    function automatic logic eff_busy(input logic [CW-1:0] cnt, input logic ret_here);
        eff_busy = (cnt > 1) || ((cnt == 1) && !ret_here);
    endfunction

    // Stall decision from read operands and the saturation guard.
    always_comb begin
        retire = we && wb_load;
        busy_a = (rna != reg_addr_t'(ZERO_REG)) && eff_busy(pend_q[rna], retire && (wn == rna));
        busy_b = (rnb != reg_addr_t'(ZERO_REG)) && eff_busy(pend_q[rnb], retire && (wn == rnb));
        full   = iss_load && (pend_q[iss_rd] == PMAX);
        stall  = !rst && (busy_a || busy_b || full);
    end

    // Counter next state: accepted issue increments, load write-back decrements.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
        end
        for (int r = 1; r < NREG; r++) begin
            if (iss_load && !stall && (iss_rd == reg_addr_t'(r)) &&
                !(retire && (wn == reg_addr_t'(r)))) begin
                pend_d[r] = pend_q[r] + 1'b1;
            end else if (retire && (wn == reg_addr_t'(r)) &&
                         !(iss_load && !stall && (iss_rd == reg_addr_t'(r))) &&
                         (pend_q[r] != '0)) begin
                pend_d[r] = pend_q[r] - 1'b1;
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Register file with write-back bypass on both read ports and a load-use scoreboard.
module reg_file
    import cpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = XLEN,
    parameter int CW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    rna,
    input  logic [4:0]    rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    input  logic          we,
    input  logic [4:0]    wn,
    input  logic [DW-1:0] wdi,
    input  logic          wb_load,
    input  logic          iss_load,
    input  logic [4:0]    iss_rd,
    output logic          stall
);

    logic [DW-1:0] mem_q [NREG];

    // Register 0 reads as zero; a same-cycle write to the address wins over the array.
    function automatic logic [DW-1:0] rd_port(input reg_addr_t addr);
        if (addr == reg_addr_t'(ZERO_REG)) begin
            rd_port = '0;
        end else if (we && (wn == addr)) begin
            rd_port = wdi;
        end else begin
            rd_port = mem_q[addr];
        end
    endfunction

    // Array update; reset clears every entry and discards a concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else if (we && (wn != reg_addr_t'(ZERO_REG))) begin
            mem_q[wn] <= wdi;
        end
    end

    // Read ports present the cleared array while reset is held.
    always_comb begin
        qa = rst ? '0 : rd_port(rna);
        qb = rst ? '0 : rd_port(rnb);
    end

    load_scoreboard #(
        .NREG (NREG),
        .CW   (CW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rna      (rna),
        .rnb      (rnb),
        .we       (we),
        .wn       (wn),
        .wb_load  (wb_load),
        .iss_load (iss_load),
        .iss_rd   (iss_rd),
        .stall    (stall)
    );

endmodule
